// File: rtl/spi_frame_guard.sv
// Header-checked frame loader with arming and watchdog fallback to an all-zero safe frame.
// Optional build macro FRAME_GUARD_STICKY_EN makes the TIMEOUT state terminal until reset.
module spi_frame_guard #(
    parameter int          FRAME_BITS     = 400,
    parameter logic [31:0] HEADER         = 32'h74697277,
    parameter int          TIMEOUT_CYCLES = 5000000,
    parameter int          ARM_FRAMES     = 2
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] rx_data,
    input  logic                  frame_stb,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  new_frame,
    output logic                  running,
    output logic                  timeout,
    output logic [15:0]           frame_cnt,
    output logic [7:0]            err_cnt
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ARM_W  = $clog2(ARM_FRAMES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_TIMEOUT
    } state_t;

    state_t            state;
    logic [WDOG_W-1:0] wdog;
    logic [ARM_W-1:0]  arm;
    logic              hdr_ok;
    logic              hdr_bad;
    logic              can_arm;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign hdr_ok  = frame_stb && (rx_data[FRAME_BITS-1 -: 32] == HEADER);
    assign hdr_bad = frame_stb && !hdr_ok;

`ifdef FRAME_GUARD_STICKY_EN
    assign can_arm = (state == S_IDLE);
`else
    assign can_arm = (state == S_IDLE) || (state == S_TIMEOUT);
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            frame_out <= '0;
            new_frame <= 1'b0;
            running   <= 1'b0;
            timeout   <= 1'b0;
            wdog      <= '0;
            arm       <= '0;
        end else begin
            new_frame <= 1'b0;
            case (state)
                S_RUN: begin
                    // A frame arriving on the expiry cycle takes priority over the timeout.
                    if (hdr_ok) begin
                        frame_out <= rx_data;
                        new_frame <= 1'b1;
                        wdog      <= '0;
                    end else if (wdog == WDOG_LAST) begin
                        frame_out <= '0;
                        wdog      <= '0;
                        state     <= S_TIMEOUT;
                        running   <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                default: begin
                    if (hdr_ok && can_arm) begin
                        if (arm == ARM_LAST) begin
                            frame_out <= rx_data;
                            new_frame <= 1'b1;
                            arm       <= '0;
                            wdog      <= '0;
                            state     <= S_RUN;
                            running   <= 1'b1;
                            timeout   <= 1'b0;
                        end else begin
                            arm <= arm + ARM_W'(1);
                        end
                    end else if (hdr_bad) begin
                        arm <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (hdr_ok)
                frame_cnt <= frame_cnt + 16'd1;
            if (hdr_bad)
                err_cnt <= sat_inc8(err_cnt);
        end
    end

endmodule
